// File: rtl/dual_lane_serializer.sv
// Two-lane serializer: preamble, WIDTH/2 data cycles (even bits on lane0, odd on lane1), one parity cycle.
// Outputs are registered (1-cycle latency from accept); tx_en low freezes everything, in_ready only when idle or in parity.
module dual_lane_serializer #(
  parameter int WIDTH    = 8,
  parameter int PAD_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             lane0,
  output logic             lane1,
  output logic             frame,
  output logic             busy
);

  localparam int HALF = WIDTH / 2;
  localparam int MAXC = (PAD_BITS > HALF) ? PAD_BITS : HALF;
  localparam int CW   = $clog2(MAXC + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("dual_lane_serializer: WIDTH must be even and >= 4");
  end
  if (PAD_BITS < 1) begin : g_bad_pad
    $error("dual_lane_serializer: PAD_BITS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, PARITY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              lane0_q, lane0_d;
  logic              lane1_q, lane1_d;
  logic              frame_q, frame_d;
  logic              busy_q, busy_d;
  logic              accept;

  function automatic logic xor_bits(input logic [WIDTH-1:0] w, input int first);
    logic p;
    p = 1'b0;
    for (int i = first; i < WIDTH; i += 2) p ^= w[i];
    return p;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    in_ready = tx_en && !rst && (state_q == IDLE || state_q == PARITY);
    accept   = in_ready && in_valid;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PREAMBLE;
          cnt_d   = '0;
          shift_d = in_data;
        end
      end
      PREAMBLE: begin
        if (cnt_q == CW'(PAD_BITS - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        // Rotate rather than shift: after HALF steps the word is whole again for parity.
        shift_d = {shift_q[1:0], shift_q[WIDTH-1:2]};
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        cnt_d = '0;
        if (accept) begin
          state_d = PREAMBLE;
          shift_d = in_data;
        end else begin
          state_d = IDLE;
          shift_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase

    lane0_d = 1'b0;
    lane1_d = 1'b0;
    frame_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      PREAMBLE: lane0_d = 1'b1;
      DATA: begin
        lane0_d = shift_d[0];
        lane1_d = shift_d[1];
      end
      PARITY: begin
        lane0_d = xor_bits(shift_d, 0);
        lane1_d = xor_bits(shift_d, 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      lane0_q <= 1'b0;
      lane1_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (tx_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign lane0 = lane0_q;
  assign lane1 = lane1_q;
  assign frame = frame_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dual_lane_serializer.sv
// Directed bench for dual_lane_serializer (WIDTH=8, PAD_BITS=2) with hand-computed lane sequences.
module tb_dual_lane_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       lane0;
  logic       lane1;
  logic       frame;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  dual_lane_serializer #(.WIDTH(8), .PAD_BITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .lane0    (lane0),
    .lane1    (lane1),
    .frame    (frame),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks {busy,frame,lane1,lane0} and in_ready for n cycles of one frame; bit k of each vector is cycle k.
  task automatic run_seq(input string tag, input int n, input logic [15:0] l0,
                         input logic [15:0] l1, input logic [15:0] en_low, input logic ends_ready);
    for (int k = 0; k < n; k++) begin
      tx_en = !en_low[k];
      #1;
      check($sformatf("%s_out%0d", tag, k), {28'd0, busy, frame, l1[k], l0[k]}, {28'd0, 1'b1, 1'b1, l1[k], l0[k]});
      check($sformatf("%s_rdy%0d", tag, k), {31'd0, in_ready}, {31'd0, (k == n - 1) && ends_ready});
      step();
    end
    tx_en = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    #1;
    check(tag, {28'd0, busy, frame, lane1, lane0}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("rst_out");
    check("idle_rdy", {31'd0, in_ready}, 32'd1);
    tx_en = 1'b0;
    #1;
    check("idle_noen_rdy", {31'd0, in_ready}, 32'd0);
    step();
    tx_en = 1'b1;
    check_idle("idle_noen_out");

    // Single word 0x01; in_data scrambled after acceptance.
    in_valid = 1'b1;
    in_data  = 8'h01;
    #1;
    check("h01_acc_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    run_seq("h01", 7, 16'h0047, 16'h0000, 16'h0000, 1'b1);
    check_idle("h01_end");

    // Back-to-back A5 then 3C with in_valid held; 3C presented while A5 is busy.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_data = 8'h3C;
    run_seq("hA5", 7, 16'h000F, 16'h0030, 16'h0000, 1'b1);
    in_valid = 1'b0;
    in_data  = 8'h00;
    run_seq("h3C", 7, 16'h001B, 16'h0018, 16'h0000, 1'b1);
    check_idle("h3C_end");

    // A5 with tx_en low for three cycles starting in DATA cycle 1.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    run_seq("hold", 10, 16'h007F, 16'h0180, 16'h0038, 1'b1);
    check_idle("hold_end");

    // FF interrupted by reset in DATA cycle 2, then a fresh 0x02 frame.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    run_seq("hFF", 4, 16'h000F, 16'h000C, 16'h0000, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h02;
    #1;
    check("hFF_d2_out", {28'd0, busy, frame, lane1, lane0}, 32'hF);
    check("rst_mid_rdy", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    check_idle("rst_mid_out");
    check("rst_fall_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    run_seq("h02", 7, 16'h0003, 16'h0044, 16'h0000, 1'b1);
    check_idle("h02_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
